// File: rtl/mem_access_ctrl_pkg.sv
// Shared encodings and types for the data-memory access sequencer.
// Optional feature macro (used by mem_access_ctrl): MEM_TIMEOUT_EN.
package mem_access_ctrl_pkg;

  localparam logic [2:0] FUNCT3_LB  = 3'd0;
  localparam logic [2:0] FUNCT3_LH  = 3'd1;
  localparam logic [2:0] FUNCT3_LW  = 3'd2;
  localparam logic [2:0] FUNCT3_LBU = 3'd4;
  localparam logic [2:0] FUNCT3_LHU = 3'd5;
  localparam logic [2:0] FUNCT3_SB  = 3'd0;
  localparam logic [2:0] FUNCT3_SH  = 3'd1;
  localparam logic [2:0] FUNCT3_SW  = 3'd2;

  typedef enum logic [1:0] {
    MEM_ST_IDLE = 2'd0,
    MEM_ST_BUSY = 2'd1,
    MEM_ST_RESP = 2'd2
  } mem_state_e;

  // Registered write-side payload presented to the memory port.
  typedef struct packed {
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } mem_lane_t;

  function automatic logic funct3_illegal(input logic store, input logic [2:0] f3);
    if (store) return f3 > FUNCT3_SW;
    return (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
  endfunction

endpackage

// File: rtl/mem_access_ctrl_lane.sv
// mem_lane_align: byte-lane steering, store replication, load extension, alignment check.
module mem_lane_align
  import mem_access_ctrl_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr,
  input  logic [31:0] wdata,
  input  logic [31:0] mem_rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext,
  output logic        misaligned
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    be         = 4'b0000;
    wdata_rep  = 32'h0;
    misaligned = 1'b0;
    // funct3[1:0] is the access size for both loads and stores
    case (funct3[1:0])
      2'd0: begin
        be        = 4'b0001 << addr;
        wdata_rep = {4{wdata[7:0]}};
      end
      2'd1: begin
        be         = addr[1] ? 4'b1100 : 4'b0011;
        wdata_rep  = {2{wdata[15:0]}};
        misaligned = addr[0];
      end
      2'd2: begin
        be         = 4'b1111;
        wdata_rep  = wdata;
        misaligned = (addr != 2'd0);
      end
      default: ;
    endcase
  end

  always_comb begin
    case (addr)
      2'd0:    byte_sel = mem_rdata[7:0];
      2'd1:    byte_sel = mem_rdata[15:8];
      2'd2:    byte_sel = mem_rdata[23:16];
      default: byte_sel = mem_rdata[31:24];
    endcase
    half_sel = addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (funct3)
      FUNCT3_LB:  rdata_ext = {{24{byte_sel[7]}}, byte_sel};
      FUNCT3_LH:  rdata_ext = {{16{half_sel[15]}}, half_sel};
      FUNCT3_LW:  rdata_ext = mem_rdata;
      FUNCT3_LBU: rdata_ext = {24'h0, byte_sel};
      FUNCT3_LHU: rdata_ext = {16'h0, half_sel};
      default:    rdata_ext = 32'h0;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Multi-cycle load/store sequencer between the execute stage and the data-memory port.
// Optional macro MEM_TIMEOUT_EN adds a bounded wait for mem_ack.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              is_store,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              ready,
  output logic              stall,
  output logic              done,
  output logic              err,
  output logic [31:0]       rdata_out,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata
);

  mem_state_e        state_q, state_d;
  logic              is_store_q, is_store_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [1:0]        off_q, off_d;
  logic              err_q, err_d;
  mem_lane_t         lane_q, lane_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              timeout_hit;

  logic [2:0]  sel_f3;
  logic [1:0]  sel_off;
  logic [3:0]  la_be;
  logic [31:0] la_wdata;
  logic [31:0] la_rdata;
  logic        la_misaligned;

  // Steer from live inputs while accepting, from latched request afterwards.
  assign sel_f3  = (state_q == MEM_ST_IDLE) ? funct3 : funct3_q;
  assign sel_off = (state_q == MEM_ST_IDLE) ? addr[1:0] : off_q;

  mem_lane_align u_lane (
    .funct3     (sel_f3),
    .addr       (sel_off),
    .wdata      (wdata),
    .mem_rdata  (mem_rdata),
    .be         (la_be),
    .wdata_rep  (la_wdata),
    .rdata_ext  (la_rdata),
    .misaligned (la_misaligned)
  );

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout_hit        = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    is_store_d = is_store_q;
    funct3_d   = funct3_q;
    off_d      = off_q;
    err_d      = err_q;
    lane_d     = lane_q;
    addr_d     = addr_q;
    rdata_d    = rdata_q;
`ifdef MEM_TIMEOUT_EN
    cnt_d      = cnt_q;
`endif
    case (state_q)
      MEM_ST_IDLE: begin
        if (start) begin
          is_store_d = is_store;
          funct3_d   = funct3;
          off_d      = addr[1:0];
          if (la_misaligned || funct3_illegal(is_store, funct3)) begin
            err_d   = 1'b1;
            state_d = MEM_ST_RESP;
          end else begin
            err_d        = 1'b0;
            lane_d.we    = is_store;
            lane_d.be    = la_be;
            lane_d.wdata = is_store ? la_wdata : 32'h0;
            addr_d       = {addr[ADDR_W-1:2], 2'b00};
            state_d      = MEM_ST_BUSY;
`ifdef MEM_TIMEOUT_EN
            cnt_d        = '0;
`endif
          end
        end
      end
      MEM_ST_BUSY: begin
        if (mem_ack) begin
          if (!is_store_q) rdata_d = la_rdata;
          lane_d  = '0;
          addr_d  = '0;
          state_d = MEM_ST_RESP;
        end else if (timeout_hit) begin
          rdata_d = 32'h0;
          err_d   = 1'b1;
          lane_d  = '0;
          addr_d  = '0;
          state_d = MEM_ST_RESP;
        end else begin
`ifdef MEM_TIMEOUT_EN
          cnt_d = cnt_q + CNT_W'(1);
`endif
        end
      end
      MEM_ST_RESP: state_d = MEM_ST_IDLE;
      default:     state_d = MEM_ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= MEM_ST_IDLE;
      is_store_q <= 1'b0;
      funct3_q   <= 3'd0;
      off_q      <= 2'd0;
      err_q      <= 1'b0;
      lane_q     <= '0;
      addr_q     <= '0;
      rdata_q    <= 32'h0;
`ifdef MEM_TIMEOUT_EN
      cnt_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      is_store_q <= is_store_d;
      funct3_q   <= funct3_d;
      off_q      <= off_d;
      err_q      <= err_d;
      lane_q     <= lane_d;
      addr_q     <= addr_d;
      rdata_q    <= rdata_d;
`ifdef MEM_TIMEOUT_EN
      cnt_q      <= cnt_d;
`endif
    end
  end

  // Status decodes straight from flops; stall also reacts to start so the PC holds on accept.
  assign ready     = (state_q == MEM_ST_IDLE);
  assign done      = (state_q == MEM_ST_RESP);
  assign err       = done && err_q;
  assign stall     = ((state_q == MEM_ST_IDLE) && start) || (state_q == MEM_ST_BUSY);
  assign mem_req   = (state_q == MEM_ST_BUSY);
  assign mem_we    = lane_q.we;
  assign mem_be    = lane_q.be;
  assign mem_wdata = lane_q.wdata;
  assign mem_addr  = addr_q;
  assign rdata_out = rdata_q;

endmodule
